ram_stream_reader: RTL

- Read-side companion to the team's distributed RAMs (11 entries, 11-bit address, asynchronous read port).
- On a start command it walks a contiguous address range through the RAM's read port (raddr/rdata pair).
- Each word goes out on a valid/ready stream, tagged with last, through a 2-entry output buffer.
- Sits between a RAM written by upstream logic and a downstream consumer that applies backpressure.

---
 rtl/ram_stream_reader.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks a contiguous RAM address range through an
// asynchronous read port and streams each word out on a valid/ready
// interface (with last) through a 2-entry output buffer.
module ram_stream_reader #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 11,
   parameter int DEPTH  = 11
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W-1:0] i_len,
   output logic              o_busy,
   output logic              o_done,
   output logic              o_err,
   output logic [ADDR_W-1:0] o_ram_ra,
   input  logic [DATA_W-1:0] i_ram_rd,
   output logic [DATA_W-1:0] o_m_data,
   output logic              o_m_valid,
   input  logic              i_m_ready,
   output logic              o_m_last
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_READ  = 2'd1,
      S_DRAIN = 2'd2,
      S_FIN   = 2'd3
   } state_t;

   localparam logic [ADDR_W-1:0] LP_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_addr;
   logic [ADDR_W-1:0]   r_rem;
   logic                r_err;
   logic [1:0]          r_cnt;
   logic                r_rd_ptr;
   logic                r_wr_ptr;
   logic [DATA_W-1:0]   r_buf_data [0:1];
   logic                r_buf_last [0:1];

   logic [ADDR_W:0]     w_end;
   logic                w_len_zero;
   logic                w_range_bad;
   logic                w_accept;
   logic                w_last_fetch;
   logic                w_pop;
   logic                w_push;

   // Range check is one bit wider than the address so base+len cannot wrap.
   assign w_end        = {1'b0, i_base} + {1'b0, i_len};
   assign w_len_zero   = (i_len == {ADDR_W{1'b0}});
   assign w_range_bad  = (w_end > LP_DEPTH);
   assign w_accept     = (r_state == S_IDLE) && i_start;
   assign w_last_fetch = (r_rem == LP_ONE);

   // Stream outputs come straight from the buffer head; last is qualified by valid.
   assign o_m_valid = (r_cnt != 2'd0);
   assign o_m_data  = r_buf_data[r_rd_ptr];
   assign o_m_last  = o_m_valid && r_buf_last[r_rd_ptr];
   assign o_ram_ra  = r_addr;
   assign o_busy    = (r_state != S_IDLE);
   assign o_done    = (r_state == S_FIN);
   assign o_err     = (r_state == S_FIN) && r_err;

   // Handshake and fetch decisions: fetch while buffer has room, or is full but draining.
   always_comb begin
      w_pop  = 1'b0;
      w_push = 1'b0;
      if (o_m_valid && i_m_ready) begin
         w_pop = 1'b1;
      end else begin
         w_pop = 1'b0;
      end
      if (r_state == S_READ) begin
         if (r_cnt < 2'd2) begin
            w_push = 1'b1;
         end else begin
            w_push = w_pop;
         end
      end else begin
         w_push = 1'b0;
      end
   end

   // Next-state logic for the command sequencer.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               if (w_len_zero || w_range_bad) begin
                  w_state_nxt = S_FIN;
               end else begin
                  w_state_nxt = S_READ;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_READ: begin
            if (w_push && w_last_fetch) begin
               w_state_nxt = S_DRAIN;
            end else begin
               w_state_nxt = S_READ;
            end
         end
         S_DRAIN: begin
            if (w_pop && (r_cnt == 2'd1)) begin
               w_state_nxt = S_FIN;
            end else begin
               w_state_nxt = S_DRAIN;
            end
         end
         S_FIN: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Command registers: address walker, remaining count and pending error flag.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_addr <= {ADDR_W{1'b0}};
         r_rem  <= {ADDR_W{1'b0}};
         r_err  <= 1'b0;
      end else if (w_accept) begin
         r_err <= (!w_len_zero) && w_range_bad;
         if (!w_len_zero && !w_range_bad) begin
            r_addr <= i_base;
            r_rem  <= i_len;
         end
      end else if (w_push) begin
         r_addr <= r_addr + LP_ONE;
         r_rem  <= r_rem - LP_ONE;
      end
   end

   // Two-entry output FIFO; a push and pop in the same cycle keep the count.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_cnt         <= 2'd0;
         r_rd_ptr      <= 1'b0;
         r_wr_ptr      <= 1'b0;
         r_buf_data[0] <= {DATA_W{1'b0}};
         r_buf_data[1] <= {DATA_W{1'b0}};
         r_buf_last[0] <= 1'b0;
         r_buf_last[1] <= 1'b0;
      end else begin
         if (w_push) begin
            r_buf_data[r_wr_ptr] <= i_ram_rd;
            r_buf_last[r_wr_ptr] <= w_last_fetch;
            r_wr_ptr             <= ~r_wr_ptr;
         end
         if (w_pop) begin
            r_rd_ptr <= ~r_rd_ptr;
         end
         case ({w_push, w_pop})
            2'b10:   r_cnt <= r_cnt + 2'd1;
            2'b01:   r_cnt <= r_cnt - 2'd1;
            default: r_cnt <= r_cnt;
         endcase
      end
   end

endmodule
